data_ram: RTL and testbench

//  Data-memory responder on the core's MEM-stage load/store port (ram_addr/ram_data/ram_we/ram_sel/ram_ce).

---
 rtl/data_ram.sv | 105 ++++++++++
 tb/tb_data_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Data memory for the MEM-stage load/store port: byte-lane synchronous writes,
// combinational word reads, post-reset clear sweep, sticky range error and
// saturating load/store counters.
module data_ram #(
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready,
  output logic        err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned LANES    = 4;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              access;
  logic              rd_en;
  logic              wr_en;
  logic              unused_addr_bits;

  // Address decode and access qualification
  assign idx              = addr[ADDR_W+1:2];
  assign in_range         = (addr[31:ADDR_W+2] == '0);
  assign access           = (state == ST_READY) && ce;
  assign rd_en            = access && in_range && !we;
  assign wr_en            = access && in_range && we && (sel != 4'b0000);
  assign unused_addr_bits = ^addr[1:0];

  // Combinational load data; zero whenever no load is being serviced
  assign data_o = rd_en ? mem[idx] : 32'h0000_0000;

  // Control FSM, sweep pointer, sticky error and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      ready   <= !CLEAR_ON_RESET;
      clr_ptr <= '0;
      err     <= 1'b0;
      rd_cnt  <= 32'h0000_0000;
      wr_cnt  <= 32'h0000_0000;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == LAST_IDX) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (ce && !in_range) begin
            err <= 1'b1;
          end
          if (rd_en && (rd_cnt != CNT_MAX)) begin
            rd_cnt <= rd_cnt + 32'd1;
          end
          if (wr_en && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 32'd1;
          end
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

  // Array writes: sweep zeroing in CLEAR, per-lane stores in READY
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= 32'h0000_0000;
      end else if (wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (sel[i]) begin
            mem[idx][8*i +: 8] <= data_i[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Randomized self-checking bench for data_ram (ADDR_W=4) against a
// behavioural memory model.
module tb_data_ram;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] MAXV   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        ready;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  logic [31:0] nc_data_o;
  logic        nc_ready;
  logic        nc_err;
  logic [31:0] nc_rd_cnt;
  logic [31:0] nc_wr_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit          m_valid = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_err   = 1'b0;
  int          m_sweep = 0;
  logic [31:0] m_rd    = 32'h0;
  logic [31:0] m_wr    = 32'h0;
  logic [31:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  data_ram #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .ready(ready), .err(err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  data_ram #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(nc_data_o), .ready(nc_ready), .err(nc_err),
    .rd_cnt(nc_rd_cnt), .wr_cnt(nc_wr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 32'h0;
  endfunction

  function automatic logic [31:0] model_rdata(input logic c, input logic w, input logic [31:0] a);
    if (!m_ready || !c || w || !model_in_range(a)) return 32'h0;
    return m_mem[a[ADDR_W+1:2]];
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic w,
                            input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if (r) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_sweep = DEPTH;
      m_err   = 1'b0;
      m_rd    = 32'h0;
      m_wr    = 32'h0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (!m_ready) begin
      m_sweep--;
      if (m_sweep == 0) m_ready = 1'b1;
    end else if (c) begin
      if (!model_in_range(a)) begin
        m_err = 1'b1;
      end else if (w) begin
        if (s != 4'h0) begin
          for (int i = 0; i < 4; i++)
            if (s[i]) m_mem[a[ADDR_W+1:2]][8*i +: 8] = d[8*i +: 8];
          if (m_wr != MAXV) m_wr = m_wr + 32'd1;
        end
      end else begin
        if (m_rd != MAXV) m_rd = m_rd + 32'd1;
      end
    end
  endtask

  // One clock cycle: drive, check load data before the edge, check state after it
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    rst = r; ce = c; we = w; addr = a; sel = s; data_i = d;
    #1;
    if (m_valid) check_eq("data_o", data_o, model_rdata(c, w, a));
    @(posedge clk);
    model_edge(r, c, w, a, s, d);
    #1;
    if (m_valid) begin
      check_eq("ready", 32'(ready), 32'(m_ready));
      check_eq("err", 32'(err), 32'(m_err));
      check_eq("rd_cnt", rd_cnt, m_rd);
      check_eq("wr_cnt", wr_cnt, m_wr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, s, d);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    logic        rw;
    logic        rc;
    logic        rr;

    // reset, then sweep; also check the no-clear variant is ready at once
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check_eq("nc_ready", 32'(nc_ready), 32'd1);
    check_eq("nc_err", 32'(nc_err), 32'd0);
    check_eq("nc_rd_cnt", nc_rd_cnt, 32'h0);
    check_eq("nc_wr_cnt", nc_wr_cnt, 32'h0);
    check_eq("nc_data_o", nc_data_o, 32'h0);
    idle(16);
    check_eq("ready_after_sweep", 32'(ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) load(32'(i) << 2);

    // byte-lane merge
    store(32'h8, 4'hF, 32'h1122_3344);
    store(32'h8, 4'b0101, 32'hAABB_CCDD);
    load(32'h8);
    check_eq("merge_word", m_mem[2], 32'h11BB_33DD);

    // out-of-range store
    store(32'h100, 4'hF, 32'hDEAD_BEEF);
    idle(2);
    for (int i = 0; i < DEPTH; i++) load(32'(i) << 2);

    // sel=0 store, low address bits ignored
    store(32'h4, 4'hF, 32'hCAFE_F00D);
    store(32'h4, 4'h0, 32'h1234_5678);
    load(32'h6);

    // reset mid-sweep restarts it; store during sweep is dropped
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(3);
    store(32'h8, 4'hF, 32'h5555_AAAA);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(15);
    check_eq("ready_before_16", 32'(ready), 32'd0);
    idle(1);
    check_eq("ready_at_16", 32'(ready), 32'd1);
    load(32'h8);

    // load counter saturation
    force dut.rd_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.rd_cnt;
    m_rd = 32'hFFFF_FFFE;
    load(32'h0);
    load(32'h4);
    load(32'h8);
    check_eq("rd_cnt_sat", rd_cnt, MAXV);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      rc = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) == 1;
      rs = 4'($urandom_range(0, 15));
      rd = $urandom;
      ra = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) ra = $urandom | 32'h40;
      cycle(rr, rc, rw, ra, rs, rd);
    end
    for (int i = 0; i < DEPTH; i++) load(32'(i) << 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
